// File: rtl/matrix_pkt_dispatcher.sv
// Packet dispatcher: steers whole sop..eop packets from one upstream stream to
// one of NUM_CH matrix engines, granting round-robin among enabled engines.
// Optional per-channel packet and drop counters are built when the
// DISPATCH_STATS_EN macro is defined; otherwise the counter ports read zero.
module matrix_pkt_dispatcher #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic                     in_vld,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        ch_sop,
  output logic [NUM_CH-1:0]        ch_eop,
  output logic [NUM_CH-1:0]        ch_vld,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     err_pulse,
  output logic [NUM_CH*16-1:0]     pkt_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          rr_ptr, rr_nxt, cur_nxt;
  logic [CH_W-1:0]          grant, idx;
  logic [CH_W-1:0]          fwd_ch;
  logic                     fwd, fwd_sop, err_nxt;
  logic [NUM_CH-1:0]        sop_nxt, eop_nxt, vld_nxt;
  logic [NUM_CH*DATA_W-1:0] data_nxt;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return CH_W'((32'(c) + 32'd1) % NUM_CH);
  endfunction

  assign in_ready = (state == IDLE) && (|ch_enable);
  assign busy     = (state == BUSY);

  // Round-robin search: first enabled channel starting at rr_ptr
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((32'(rr_ptr) + 32'(k)) % NUM_CH);
      if (ch_enable[idx]) grant = idx;
    end
  end

  // Next-state, steering and error decode
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cur_nxt   = cur_ch;
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    fwd_ch    = cur_ch;
    err_nxt   = 1'b0;
    sop_nxt   = '0;
    eop_nxt   = '0;
    vld_nxt   = '0;
    data_nxt  = '0;
    case (state)
      IDLE: begin
        if (in_vld && in_sop) begin
          if (in_ready) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            fwd_ch  = grant;
            cur_nxt = grant;
            if (in_eop) rr_nxt = ch_inc(grant);
            else        state_nxt = BUSY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (in_vld) begin
          fwd     = 1'b1;
          err_nxt = in_sop;
          if (in_eop) begin
            state_nxt = IDLE;
            rr_nxt    = ch_inc(cur_ch);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (fwd && (fwd_ch == CH_W'(i))) begin
        sop_nxt[i]                  = fwd_sop;
        eop_nxt[i]                  = in_eop;
        vld_nxt[i]                  = 1'b1;
        data_nxt[i*DATA_W +: DATA_W] = in_data;
      end
    end
  end

  // State, pointer and registered channel outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      ch_sop    <= '0;
      ch_eop    <= '0;
      ch_vld    <= '0;
      ch_data   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      cur_ch    <= cur_nxt;
      ch_sop    <= sop_nxt;
      ch_eop    <= eop_nxt;
      ch_vld    <= vld_nxt;
      ch_data   <= data_nxt;
      err_pulse <= err_nxt;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic                   accept, drop;
  logic [NUM_CH*CNT_W-1:0] pkt_q;
  logic [CNT_W-1:0]        drop_q;

  assign accept = (state == IDLE) && in_vld && in_sop && in_ready;
  assign drop   = (state == IDLE) && in_vld && in_sop && !in_ready;

  // Per-channel accepted-packet counters (wrap) and saturating drop counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (accept && (grant == CH_W'(i)))
          pkt_q[i*CNT_W +: CNT_W] <= pkt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (drop && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_pkt_dispatcher.sv
// Self-checking bench for matrix_pkt_dispatcher against a packet-level model.
module tb_matrix_pkt_dispatcher;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 2;
  localparam int VW  = 3*NCH + NCH*DW + 1 + CW + 1 + NCH*16 + 16;
`ifdef DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic [NCH-1:0]    ch_enable = '0;
  logic [NCH-1:0]    ch_sop, ch_eop, ch_vld;
  logic [NCH*DW-1:0] ch_data;
  logic              busy, err_pulse;
  logic [CW-1:0]     cur_ch;
  logic [NCH*16-1:0] pkt_cnt;
  logic [15:0]       drop_cnt;

  matrix_pkt_dispatcher #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_data(in_data),
    .in_ready(in_ready), .ch_enable(ch_enable),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_vld(ch_vld), .ch_data(ch_data),
    .busy(busy), .cur_ch(cur_ch), .err_pulse(err_pulse),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  wire [VW-1:0] act_vec = {ch_sop, ch_eop, ch_vld, ch_data, busy, cur_ch,
                           err_pulse, pkt_cnt, drop_cnt};

  int n_cmp = 0;
  int n_err = 0;

  // Packet-level reference model
  bit        m_busy;
  int        m_cur, m_rr, m_drop;
  int        m_pkt [NCH];
  logic [VW-1:0] exp_vec;
  logic      e_ready, seen_ready;

  task automatic model_reset();
    m_busy = 1'b0; m_cur = 0; m_rr = 0; m_drop = 0;
    for (int c = 0; c < NCH; c++) m_pkt[c] = 0;
  endtask

  task automatic apply_reset();
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one input cycle, predict the registered result, land #1 after the edge
  task automatic step(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    int g, first;
    logic [NCH-1:0]    es, ee, ev;
    logic [NCH*DW-1:0] ed;
    logic [NCH*16-1:0] ep;
    logic              eerr;
    @(negedge sys_clk);
    in_vld = v; in_sop = s; in_eop = e; in_data = d;
    #1;
    seen_ready = in_ready;
    e_ready = !m_busy && (ch_enable != '0);
    es = '0; ee = '0; ev = '0; ed = '0; eerr = 1'b0; g = -1; first = 0;
    if (v) begin
      if (!m_busy) begin
        if (s) begin
          if (ch_enable != '0) begin
            for (int k = 0; k < NCH; k++)
              if (g < 0 && ch_enable[CW'((m_rr + k) % NCH)]) g = (m_rr + k) % NCH;
            m_cur = g; m_pkt[g]++; first = 1;
            if (e) m_rr = (g + 1) % NCH; else m_busy = 1'b1;
          end else begin
            eerr = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end else begin
        g = m_cur;
        if (s) eerr = 1'b1;
        if (e) begin m_busy = 1'b0; m_rr = (g + 1) % NCH; end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (c == g) begin
        es[c] = (first != 0); ee[c] = e; ev[c] = 1'b1; ed[c*DW +: DW] = d;
      end
      ep[c*16 +: 16] = STATS ? 16'(m_pkt[c]) : 16'd0;
    end
    exp_vec = {es, ee, ev, ed, m_busy, CW'(m_cur), eerr, ep,
               STATS ? 16'(m_drop) : 16'd0};
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    ch_enable = '0;
    apply_reset();
    #1;
    n_cmp++;
    if (act_vec !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h exp 0", act_vec);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready_noen: got %b exp 0", in_ready);
    end
    ch_enable = 4'hF; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_en: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_rr_all();
    apply_reset();
    ch_enable = 4'hF;
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 3; w++) begin
        step(1'b1, w == 0, w == 2, $urandom);
        n_cmp++;
        if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
          n_err++; $display("FAIL rr_all p%0d w%0d: got %h exp %h", p, w, {seen_ready, act_vec}, {e_ready, exp_vec});
        end
        n_cmp++;
        if (cur_ch !== CW'(p) || ch_vld !== (4'b1 << p) || ch_sop[p] !== (w == 0) || ch_eop[p] !== (w == 2)) begin
          n_err++; $display("FAIL rr_all_chan p%0d w%0d: got ch=%0d vld=%b sop=%b eop=%b", p, w, cur_ch, ch_vld, ch_sop, ch_eop);
        end
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch [3] = '{1, 3, 1};
    apply_reset();
    ch_enable = 4'b1010;
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 2; w++) begin
        step(1'b1, w == 0, w == 1, $urandom);
        n_cmp++;
        if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
          n_err++; $display("FAIL rr_sparse p%0d w%0d: got %h exp %h", p, w, {seen_ready, act_vec}, {e_ready, exp_vec});
        end
      end
      n_cmp++;
      if (cur_ch !== CW'(exp_ch[p])) begin
        n_err++; $display("FAIL rr_sparse_chan p%0d: got %0d exp %0d", p, cur_ch, exp_ch[p]);
      end
    end
  endtask

  task automatic test_drop();
    int errs = 0;
    apply_reset();
    ch_enable = '0;
    for (int w = 0; w < 3; w++) begin
      step(1'b1, w == 0, w == 2, (w == 0) ? 32'hDEADBEEF : $urandom);
      errs += int'(err_pulse);
      n_cmp++;
      if ({seen_ready, act_vec} !== {e_ready, exp_vec} || ch_vld !== '0) begin
        n_err++; $display("FAIL drop w%0d: got %h exp %h", w, {seen_ready, act_vec}, {e_ready, exp_vec});
      end
    end
    n_cmp++;
    if (errs != 1 || drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      n_err++; $display("FAIL drop_count: got errs=%0d drop=%0d exp errs=1 drop=%0d", errs, drop_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_single();
    apply_reset();
    ch_enable = 4'hF;
    step(1'b1, 1'b1, 1'b1, 32'h12345678);
    n_cmp++;
    if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
      n_err++; $display("FAIL single: got %h exp %h", {seen_ready, act_vec}, {e_ready, exp_vec});
    end
    n_cmp++;
    if (ch_sop !== 4'b0001 || ch_eop !== 4'b0001 || ch_vld !== 4'b0001 || busy !== 1'b0 || ch_data[31:0] !== 32'h12345678) begin
      n_err++; $display("FAIL single_const: got sop=%b eop=%b vld=%b busy=%b data=%h", ch_sop, ch_eop, ch_vld, busy, ch_data[31:0]);
    end
    step(1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
    n_cmp++;
    if (ch_vld !== 4'b0010 || cur_ch !== 2'd1 || {seen_ready, act_vec} !== {e_ready, exp_vec}) begin
      n_err++; $display("FAIL single_next: got vld=%b ch=%0d exp vld=0010 ch=1", ch_vld, cur_ch);
    end
  endtask

  task automatic test_sop_mid();
    apply_reset();
    ch_enable = 4'hF;
    step(1'b1, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom);
    for (int w = 0; w < 3; w++) begin
      step(1'b1, w < 2, w == 2, 32'hC0DE_0000 + 32'(w));
      n_cmp++;
      if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
        n_err++; $display("FAIL sop_mid w%0d: got %h exp %h", w, {seen_ready, act_vec}, {e_ready, exp_vec});
      end
      if (w == 1) begin
        n_cmp++;
        if (err_pulse !== 1'b1 || ch_vld !== 4'b0100 || ch_sop !== 4'b0000 || cur_ch !== 2'd2 || ch_data[64 +: 32] !== 32'hC0DE_0001) begin
          n_err++; $display("FAIL sop_mid_const: got err=%b vld=%b sop=%b ch=%0d", err_pulse, ch_vld, ch_sop, cur_ch);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ch_enable = 4'hF;
    step(1'b1, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, $urandom);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (act_vec !== '0) begin
      n_err++; $display("FAIL reset_mid: got %h exp 0", act_vec);
    end
    in_vld = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    model_reset();
    for (int w = 0; w < 2; w++) begin
      step(1'b1, w == 0, w == 1, $urandom);
      n_cmp++;
      if ({seen_ready, act_vec} !== {e_ready, exp_vec} || cur_ch !== 2'd0) begin
        n_err++; $display("FAIL reset_mid_next w%0d: got %h exp %h", w, {seen_ready, act_vec}, {e_ready, exp_vec});
      end
    end
  endtask

  task automatic test_random();
    int len;
    apply_reset();
    for (int p = 0; p < 80; p++) begin
      len = $urandom_range(1, 4);
      for (int w = 0; w < len; w++) begin
        ch_enable = NCH'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) begin
          step(1'b0, 1'($urandom), 1'($urandom), $urandom);
          n_cmp++;
          if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
            n_err++; $display("FAIL random_idle p%0d: got %h exp %h", p, {seen_ready, act_vec}, {e_ready, exp_vec});
          end
        end
        step(1'b1, (w == 0) || ($urandom_range(0, 15) == 0), w == len - 1, $urandom);
        n_cmp++;
        if ({seen_ready, act_vec} !== {e_ready, exp_vec}) begin
          n_err++; $display("FAIL random p%0d w%0d: got %h exp %h", p, w, {seen_ready, act_vec}, {e_ready, exp_vec});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_drop();
    test_single();
    test_sop_mid();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_pkt_dispatcher.md
# matrix_pkt_dispatcher

Packet dispatcher for the matrix engine array in the sys_clk domain. It accepts the single upstream matrix_memory packet stream and steers each whole packet (sop..eop) to one of NUM_CH matrix engines. Engines are granted round-robin among those reporting receive-enable, which replaces fixed-priority steering that starves higher-index engines. Outputs are registered per-channel sop/eop/vld/data buses wired directly to the engines.

## Interface
- NUM_CH, 4: number of engine channels, legal 2..8
- DATA_W, 32: packet word width
- CH_W, $clog2(NUM_CH): channel index width
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset sys_rst_n, asynchronous, active-low; clock sys_clk
- in_sop  in  1  first word of packet, qualified by in_vld
- in_eop  in  1  last word of packet, qualified by in_vld
- in_vld  in  1  word valid
- in_data  in  DATA_W  packet word
- in_ready  out  1  a new packet (sop word) may be presented this cycle
- ch_enable  in  NUM_CH  per-engine pkt_receive_enable
- ch_sop  out  NUM_CH  per-channel sop
- ch_eop  out  NUM_CH  per-channel eop
- ch_vld  out  NUM_CH  per-channel word valid
- ch_data  out  NUM_CH*DATA_W  per-channel word, channel i at [i*DATA_W +: DATA_W]
- busy  out  1  packet in progress (state BUSY)
- cur_ch  out  CH_W  channel of current or last granted packet
- err_pulse  out  1  one-cycle protocol-error flag
- pkt_cnt  out  NUM_CH*16  accepted packets per channel (see Configuration)
- drop_cnt  out  16  dropped sop words (see Configuration)

## Operation
- States: IDLE, BUSY. Reset: IDLE, rr_ptr=0, cur_ch=0.
- in_ready = (state==IDLE) && |ch_enable; combinational.
- Accept: IDLE, in_vld && in_sop && in_ready. Grant = first i with ch_enable[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CH. cur_ch<=grant; word forwarded to grant with ch_sop=1.
  - in_eop=0 -> BUSY. in_eop=1 (single-word packet) -> stay IDLE, ch_eop=1 on the same word.
- BUSY: every in_vld word forwards to cur_ch with ch_vld=1, ch_eop=in_eop; ch_enable ignored. Once granted, an engine takes the whole packet.
- End: in_vld && in_eop (BUSY, or single-word accept) -> IDLE, rr_ptr<=(grant+1) mod NUM_CH.
- Errors, all with err_pulse=1 for one cycle:
  - IDLE, in_vld && in_sop && !in_ready: word dropped, stay IDLE, rr_ptr unchanged.
  - BUSY, in_vld && in_sop: word forwarded to cur_ch as data, ch_sop=0, no regrant.
- IDLE, in_vld && !in_sop: word silently discarded, no error (tail of a dropped packet).
- in_sop/in_eop with in_vld=0: ignored.
- Non-granted channels: ch_sop/ch_eop/ch_vld=0, ch_data slice=0. Any channel with ch_vld=0 has data 0.

## Timing
- All outputs registered except in_ready. Input word at edge N appears on ch_* at edge N+1; latency 1 cycle, throughput 1 word/cycle.
- Back-to-back packets: a sop in the cycle immediately after an eop is accepted, because state is already IDLE. The grant uses the updated rr_ptr.
- ch_enable is sampled only in the accept cycle. Deassertion during BUSY does not affect the packet.
- Reset values: ch_sop/ch_eop/ch_vld=0, ch_data=0, busy=0, cur_ch=0, err_pulse=0, pkt_cnt=0, drop_cnt=0.
- Reset mid-packet: all outputs clear asynchronously and the packet is abandoned. The engine sees no eop; engine-side recovery relies on the shared sys_rst_n.
- busy rises the cycle after the accepting sop and falls the cycle after eop.

## Configuration
- DISPATCH_STATS_EN defined:
  - pkt_cnt[i*16 +: 16] increments on each accepted sop granted to channel i; wraps 0xFFFF->0.
  - drop_cnt increments on each dropped sop (IDLE, !in_ready); saturates at 0xFFFF.
- Undefined: pkt_cnt and drop_cnt are tied to 0, no counter logic is generated, and ports remain present.

## Test plan
- All ch_enable=1, four 3-word packets back-to-back -> channels 0,1,2,3 in order; each ch_vld is high 3 cycles, ch_sop on word 1, ch_eop on word 3, 1-cycle latency.
- ch_enable=4'b1010, rr_ptr=0, two packets -> channels 1 then 3; a third packet -> channel 1.
- ch_enable=0, sop word 0xDEADBEEF followed by 2 data words -> err_pulse once; no ch_vld; drop_cnt=1 with macro, 0 without.
- Single-word packet (sop+eop, 0x12345678) with all enabled -> one cycle with ch_sop=ch_eop=ch_vld=1 on channel 0; busy stays 0; next packet goes to channel 1.
- sop mid-packet on channel 2 -> err_pulse=1; word forwarded to channel 2 with ch_sop=0; cur_ch stays 2.
- sys_rst_n low during word 2 of a 5-word packet -> all outputs 0 immediately; after release, next packet goes to channel 0.
